// File: rtl/apb_timer.sv
// apb_timer: APB slave with a 32-bit down-counting timer, one-shot or
// periodic mode, a sticky underflow flag and a level interrupt.
// Optional feature macro: APB_TIMER_PRESCALER_EN enables the 8-bit
// PRESCALE register and its PCNT counter; without it the timer ticks
// every enabled cycle and offset 0x10 reads as zero.
module apb_timer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  IRQ
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_LOAD     = 3'd1;
   localparam logic [2:0] OFF_VALUE    = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_PRESCALE = 3'd4;

   logic [2:0]            reg_idx;
   logic                  wr_access;
   logic                  rd_setup;
   logic                  wr_ctrl;
   logic                  wr_load;
   logic                  wr_status;
   logic                  ctrl_en;
   logic                  ctrl_per;
   logic                  ctrl_ie;
   logic                  irq_flag;
   logic                  tick;
   logic                  underflow;
   logic [DATA_WIDTH-1:0] load_q;
   logic [DATA_WIDTH-1:0] value_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  unused_addr;

   assign reg_idx     = PADDR[4:2];
   assign unused_addr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
   assign wr_access   = PSEL && PENABLE && PWRITE;
   assign rd_setup    = PSEL && !PENABLE && !PWRITE;
   assign wr_ctrl     = wr_access && (reg_idx == OFF_CTRL);
   assign wr_load     = wr_access && (reg_idx == OFF_LOAD);
   assign wr_status   = wr_access && (reg_idx == OFF_STATUS);

`ifdef APB_TIMER_PRESCALER_EN
   logic [7:0] prescale_q;
   logic [7:0] pcnt_q;
   logic       wr_prescale;

   assign wr_prescale = wr_access && (reg_idx == OFF_PRESCALE);
   assign tick        = ctrl_en && (pcnt_q == prescale_q);

   // PRESCALE register: low byte of the written word
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)         prescale_q <= '0;
      else if (wr_prescale) prescale_q <= PWDATA[7:0];
   end

   // Prescale counter: restarts on LOAD write, on EN 0->1, and on each tick
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                                  pcnt_q <= '0;
      else if (wr_load)                              pcnt_q <= '0;
      else if (wr_ctrl && !ctrl_en && PWDATA[0])     pcnt_q <= '0;
      else if (tick)                                 pcnt_q <= '0;
      else if (ctrl_en)                              pcnt_q <= pcnt_q + 8'd1;
   end
`else
   assign tick = ctrl_en;
`endif

   // A LOAD write in the same cycle as a tick suppresses the underflow
   assign underflow = tick && (value_q == '0) && !wr_load;

   // CTRL register; a one-shot underflow drops EN unless software writes CTRL
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ctrl_en  <= 1'b0;
         ctrl_per <= 1'b0;
         ctrl_ie  <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en  <= PWDATA[0];
         ctrl_per <= PWDATA[1];
         ctrl_ie  <= PWDATA[2];
      end else if (underflow && !ctrl_per) begin
         ctrl_en  <= 1'b0;
      end
   end

   // LOAD register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)     load_q <= '0;
      else if (wr_load) load_q <= PWDATA;
   end

   // Counter: LOAD write has priority over ticking; underflow reloads or holds 0
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         value_q <= '0;
      end else if (wr_load) begin
         value_q <= PWDATA;
      end else if (tick) begin
         if (value_q != '0) value_q <= value_q - DATA_WIDTH'(1);
         else if (ctrl_per) value_q <= load_q;
      end
   end

   // Sticky interrupt flag: set beats write-1-to-clear
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                     irq_flag <= 1'b0;
      else if (underflow)               irq_flag <= 1'b1;
      else if (wr_status && PWDATA[0])  irq_flag <= 1'b0;
   end

   // Read mux over the decoded offset; unmapped offsets read zero
   always_comb begin
      rd_data = '0;
      case (reg_idx)
         OFF_CTRL:     rd_data[2:0] = {ctrl_ie, ctrl_per, ctrl_en};
         OFF_LOAD:     rd_data = load_q;
         OFF_VALUE:    rd_data = value_q;
         OFF_STATUS:   rd_data[0] = irq_flag;
`ifdef APB_TIMER_PRESCALER_EN
         OFF_PRESCALE: rd_data[7:0] = prescale_q;
`endif
         default:      rd_data = '0;
      endcase
   end

   // Read data captured at the end of the setup phase, zeroed while deselected
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)      prdata_q <= '0;
      else if (rd_setup) prdata_q <= rd_data;
      else if (!PSEL)    prdata_q <= '0;
   end

   assign PRDATA = prdata_q;
   assign IRQ    = irq_flag && ctrl_ie;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed self-checking bench for apb_timer. Reads push
// their expected value into a scoreboard queue when driven and pop it
// when PRDATA is sampled in the access phase.
module tb_apb_timer;

   logic        clk;
   logic        hrstn;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        irq;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int base     = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

`ifdef APB_TIMER_PRESCALER_EN
   localparam int          PP      = 3;
   localparam logic [31:0] PS_RD   = 32'h2;
   localparam logic [31:0] PS_ONES = 32'hFF;
`else
   localparam int          PP      = 1;
   localparam logic [31:0] PS_RD   = 32'h0;
   localparam logic [31:0] PS_ONES = 32'h0;
`endif
   localparam int T = 2 * PP;

   apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .HCLK    (clk),
      .HRESETn (hrstn),
      .PSEL    (psel),
      .PENABLE (penable),
      .PADDR   (paddr),
      .PWRITE  (pwrite),
      .PWDATA  (pwdata),
      .PRDATA  (prdata),
      .IRQ     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected count t cycles after enable, P cycles per tick, reload L
   function automatic logic [31:0] mval(input int t, input int L, input int P, input bit per);
      int k;
      k = t / P;
      if (per)       return 32'(L - (k % (L + 1)));
      else if (k <= L) return 32'(L - k);
      else           return 32'h0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < base + t) step();
   endtask

   // Called and returns #1 after a clock edge; commits on the second edge
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      step();
      penable = 1'b1;
      step();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   // Returns the register state as it was when the task was called
   task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      string       tg;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      step();
      penable = 1'b1;
      @(negedge clk);
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      check(tg, prdata, e);
      step();
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      hrstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      #3 hrstn = 1'b1;
      step();

      // Reset asserted in the middle of a LOAD write access phase
      psel = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55;
      step();
      penable = 1'b1;
      #2 hrstn = 1'b0;
      #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      repeat (2) @(posedge clk);
      #3 hrstn = 1'b1;
      step();
      check("rst_irq", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 8; i++) apb_read(32'(i * 4), 32'h0, $sformatf("rst_off%0h", i * 4));

      // One-shot, LOAD=3, no prescale
      apb_write(32'h04, 32'd3);
      apb_read(32'h08, 32'd3, "os_value_loaded");
      apb_write(32'h00, 32'h5);
      base = cyc;
      step();
      apb_read(32'h08, mval(1, 3, 1, 1'b0), "os_value_t1");
      wait_until(3);
      check("os_irq_before", {31'b0, irq}, 32'h0);
      step();
      check("os_irq_at", {31'b0, irq}, 32'h1);
      apb_read(32'h08, 32'h0, "os_value_end");
      apb_read(32'h00, 32'h4, "os_ctrl_end");
      apb_read(32'h0C, 32'h1, "os_status_end");
      repeat (4) step();
      apb_read(32'h08, 32'h0, "os_value_hold");

      // Periodic, LOAD=1, PRESCALE=2
      apb_write(32'h0C, 32'h1);
      apb_read(32'h0C, 32'h0, "w1c_clear");
      apb_write(32'h04, 32'd1);
      apb_write(32'h10, 32'd2);
      apb_read(32'h10, PS_RD, "prescale_rd");
      apb_write(32'h00, 32'h7);
      base = cyc;
      wait_until(T - 1);
      check("per_irq_before", {31'b0, irq}, 32'h0);
      step();
      check("per_irq_first", {31'b0, irq}, 32'h1);
      wait_until(2 * T - 1);
      apb_write(32'h0C, 32'h1);
      check("per_irq_cleared", {31'b0, irq}, 32'h0);
      wait_until(3 * T - 1);
      check("per_irq_still_low", {31'b0, irq}, 32'h0);
      step();
      check("per_irq_reassert", {31'b0, irq}, 32'h1);
      wait_until(4 * T - 2);
      apb_write(32'h0C, 32'h1);
      check("coll_w1c_irq", {31'b0, irq}, 32'h1);
      apb_read(32'h0C, 32'h1, "coll_w1c_status");
      wait_until(6 * T - 2);
      apb_write(32'h04, 32'h10);
      apb_read(32'h08, 32'h10, "coll_load_value");

      // Register decode
      apb_write(32'h00, 32'h0);
      apb_write(32'h04, 32'h22);
      apb_write(32'h08, 32'hFFFF_FFFF);
      apb_read(32'h08, 32'h22, "dec_value_ro");
      for (int i = 7; i >= 0; i--) begin
         if (i != 2) apb_write(32'(i * 4), 32'hFFFF_FFFF);
      end
      apb_read(32'h00, 32'h7, "dec_ctrl");
      apb_read(32'h04, 32'hFFFF_FFFF, "dec_load");
      apb_read(32'h104, 32'hFFFF_FFFF, "dec_load_alias");
      apb_read(32'h0C, 32'h0, "dec_status");
      apb_read(32'h10, PS_ONES, "dec_prescale");
      apb_read(32'h14, 32'h0, "dec_unm14");
      apb_read(32'h18, 32'h0, "dec_unm18");
      apb_read(32'h1C, 32'h0, "dec_unm1c");
      apb_write(32'h00, 32'h0);

      // Reset in the middle of a periodic count
      apb_write(32'h10, 32'h0);
      apb_write(32'h04, 32'd100);
      apb_write(32'h00, 32'h7);
      base = cyc;
      wait_until(50);
      hrstn = 1'b0;
      repeat (2) @(posedge clk);
      #3 hrstn = 1'b1;
      step();
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 5; i++) apb_read(32'(i * 4), 32'h0, $sformatf("mid_rst_off%0h", i * 4));
      repeat (150) step();
      check("mid_rst_irq_late", {31'b0, irq}, 32'h0);
      apb_read(32'h0C, 32'h0, "mid_rst_status_late");
      apb_read(32'h08, 32'h0, "mid_rst_value_late");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_timer.md
# apb_timer

APB slave peripheral on the APB side of the AHB-to-APB bridge, which is its upstream master. Provides a 32-bit down-counting timer with programmable prescaler, one-shot or periodic mode, a sticky interrupt flag and a level interrupt output. Completes every APB transfer in the two-cycle setup/access sequence with no wait states and no error response, because the bridge samples no PREADY/PSLVERR.

## Interface
- ADDR_WIDTH, 32, APB address width; only PADDR[4:2] decoded.
- DATA_WIDTH, 32, APB data width; only 32 is supported.
- HCLK  in  1  clock; APB runs on HCLK.
- HRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select from bridge.
- PENABLE  in  1  access-phase strobe.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, registered.
- IRQ  out  1  interrupt, level, active-high.

## Operation
- Register map by PADDR[4:2], upper address bits ignored:
  - 0x00 CTRL: bit0 EN, bit1 PERIODIC (0 = one-shot), bit2 IE; other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 VALUE: current count, read-only; writes ignored.
  - 0x0C STATUS: bit0 IF, sticky; writing 1 clears it, writing 0 has no effect.
  - 0x10 PRESCALE: bits[7:0]; other bits read 0.
  - 0x14–0x1C: unmapped; read 0, writes ignored.
- Write commits on the clock edge ending the access phase (PSEL & PENABLE & PWRITE).
- Read: PRDATA is loaded on the edge ending the setup phase (PSEL & !PENABLE & !PWRITE), and is held stable through the access phase. It is cleared to 0 after any cycle with PSEL low.
- Prescaler: 8-bit counter PCNT. Tick = EN & (PCNT == PRESCALE). On a tick PCNT goes to 0; otherwise, when EN, PCNT increments.
- Counter, on a tick:
  - VALUE != 0: VALUE decrements by 1.
  - VALUE == 0: underflow event. IF is set. If PERIODIC, VALUE reloads from LOAD; if one-shot, EN clears and VALUE holds 0.
- Writing LOAD also writes the same value to VALUE and clears PCNT.
- A CTRL write that changes EN from 0 to 1 clears PCNT.
- EN = 0 freezes VALUE and PCNT.
- IRQ = IF & IE.
- Underflow period = (LOAD+1)·(PRESCALE+1) cycles.
- LOAD = 0 in periodic mode gives an underflow on every tick.
- Simultaneous events:
  - STATUS W1C and underflow in the same cycle: IF stays 1 (set wins).
  - LOAD write and tick in the same cycle: the LOAD write wins; no decrement and no underflow that cycle.
  - CTRL write of EN = 0 in the same cycle as an underflow: IF is set; EN is 0 afterwards.

## Timing
- Reset values: PRDATA 0, IRQ 0, CTRL 0, LOAD 0, VALUE 0, STATUS 0, PRESCALE 0, PCNT 0.
- Asserting HRESETn mid-count immediately returns all state to the reset values, with no pending interrupt.
- Write latency: a register changes on the edge ending the access phase and is readable from the next transfer onward.
- Read latency: zero wait states; PRDATA is valid during the whole access phase.
- With PRESCALE = 0, enabled on edge N, LOAD = L already written:
  - VALUE = L−k after edge N+k, for k ≤ L.
  - Underflow occurs on edge N+L+1; IF and IRQ (if IE) are high after that edge.
- IRQ is a combinational function of registered bits only; it has no path from the APB inputs.

## Configuration
- APB_TIMER_PRESCALER_EN defined: PRESCALE register and PCNT are implemented as described above.
- APB_TIMER_PRESCALER_EN undefined:
  - No PCNT. Tick = EN on every cycle.
  - Offset 0x10 reads 0 and writes are ignored.
  - Underflow period = LOAD+1 cycles.

## Test plan
- Reset: assert HRESETn low mid-transfer, then release -> IRQ 0; every offset 0x00–0x1C reads 0x00000000.
- One-shot: LOAD = 3, PRESCALE = 0, CTRL = 0x5 -> VALUE reads 3,2,1,0. IF = 1 and IRQ = 1 on the 4th edge after enable; CTRL reads 0x4; VALUE holds 0.
- Periodic with prescaler: LOAD = 1, PRESCALE = 2, CTRL = 0x7 -> IF sets every 6 cycles. After W1C to STATUS, IRQ drops for 1 cycle-accurate window and re-asserts 6 cycles after the previous underflow.
- Collisions:
  - W1C STATUS landing exactly on an underflow edge -> STATUS reads 1.
  - LOAD = 0x10 write landing on a tick -> VALUE reads 0x10.
- Register decode: write 0xFFFFFFFF to each offset -> CTRL reads 0x7, LOAD 0xFFFFFFFF, VALUE unchanged by its own write, PRESCALE 0xFF, unmapped offsets 0. Rerun with APB_TIMER_PRESCALER_EN undefined -> PRESCALE reads 0 and LOAD = 3 underflows 4 cycles after enable.
- Reset mid-count: LOAD = 100 periodic, assert HRESETn at count 50 -> all registers 0, IRQ 0; no underflow after release until re-programmed.
